vc_allocator: RTL and testbench

Virtual-channel allocator for one router output port. It shares that port's VIRTUAL_CHANNELS downstream VCs among the NUM_REQ input VCs in the router that request it, granting at most one downstream VC per cycle with round-robin fairness between requesters. It tracks which downstream VCs are owned and holds per-VC credit counters, which gate reallocation and feed switch allocation. Input virtual_channel instances sit in AWAITING_VC while they request; the vc_out they latch comes from this block's gnt_vc.

---
 rtl/vc_allocator_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 55 +++++
 rtl/vc_allocator.sv | 159 +++++++++++++++
 tb/tb_vc_allocator.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_allocator_pkg.sv
// Shared router constants and types used by the VC allocator and the arbiters.
// The derived widths are computed here once rather than in each module.
package vc_allocator_pkg;

    localparam int NUM_PORTS        = 5;
    localparam int VIRTUAL_CHANNELS = 2;
    localparam int DEPTH            = 5;
    localparam int VC_BITS          = $clog2(VIRTUAL_CHANNELS);
    localparam int DEPTH_BITS       = $clog2(DEPTH);
    localparam int CNT_BITS         = DEPTH_BITS + 1;

    typedef logic [VC_BITS-1:0]  vc_idx_t;
    typedef logic [CNT_BITS-1:0] credit_t;

    localparam credit_t CREDIT_FULL = credit_t'(DEPTH);

    // A VC can be handed out only when it is unowned and fully drained downstream.
    function automatic logic vc_is_free(input logic busy, input credit_t cnt);
        return (!busy) && (cnt == CREDIT_FULL);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first set request at or after ptr, wrapping
// to the lowest set request. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]        req,
    input  logic [IDX_BITS-1:0] ptr,
    output logic [N-1:0]        gnt,
    output logic [IDX_BITS-1:0] gnt_idx,
    output logic                gnt_valid
);

    logic [IDX_BITS-1:0] hi_idx_s;
    logic [IDX_BITS-1:0] lo_idx_s;
    logic                hi_valid_s;
    logic                lo_valid_s;

    // Descending scan so the last hit is the lowest index, both overall and at/after ptr.
    always_comb begin
        hi_idx_s   = '0;
        lo_idx_s   = '0;
        hi_valid_s = 1'b0;
        lo_valid_s = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx_s   = IDX_BITS'(i);
                lo_valid_s = 1'b1;
                if (IDX_BITS'(i) >= ptr) begin
                    hi_idx_s   = IDX_BITS'(i);
                    hi_valid_s = 1'b1;
                end else begin
                    hi_valid_s = hi_valid_s;
                end
            end else begin
                lo_valid_s = lo_valid_s;
            end
        end
    end

    // Prefer the wrap-free candidate, then expand the index to a one-hot grant.
    always_comb begin
        gnt_valid = lo_valid_s;
        if (hi_valid_s) begin
            gnt_idx = hi_idx_s;
        end else begin
            gnt_idx = lo_idx_s;
        end
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = gnt_valid && (gnt_idx == IDX_BITS'(i));
        end
    end

endmodule

// File: rtl/vc_allocator.sv
// Virtual-channel allocator for one output port: hands free downstream VCs to
// requesting input VCs round-robin and tracks ownership and downstream credits.
module vc_allocator
    import vc_allocator_pkg::*;
#(
    parameter int NUM_REQ  = NUM_PORTS * VIRTUAL_CHANNELS,
    parameter int REQ_BITS = $clog2(NUM_REQ)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_REQ-1:0]                   req,
    output logic [NUM_REQ-1:0]                   gnt,
    output logic [VC_BITS-1:0]                   gnt_vc,
    input  logic                                 release_valid,
    input  logic [VC_BITS-1:0]                   release_vc,
    input  logic                                 flit_sent,
    input  logic [VC_BITS-1:0]                   flit_sent_vc,
    input  logic                                 credit_return,
    input  logic [VC_BITS-1:0]                   credit_return_vc,
    output logic [VIRTUAL_CHANNELS-1:0]          vc_busy,
    output logic [VIRTUAL_CHANNELS*CNT_BITS-1:0] credits,
    output logic                                 err
);

    logic [VIRTUAL_CHANNELS-1:0] vc_busy_q, vc_busy_d;
    credit_t                     credits_q [VIRTUAL_CHANNELS];
    credit_t                     credits_d [VIRTUAL_CHANNELS];
    logic [REQ_BITS-1:0]         rr_ptr_q, rr_ptr_d;
    logic                        err_q, err_d;

    logic                        any_free_s;
    vc_idx_t                     free_vc_s;
    logic [NUM_REQ-1:0]          arb_gnt_s;
    logic [REQ_BITS-1:0]         arb_idx_s;
    logic                        arb_valid_s;
    logic                        grant_s;

    rr_arbiter #(
        .N        (NUM_REQ),
        .IDX_BITS (REQ_BITS)
    ) u_rr_arbiter (
        .req       (req),
        .ptr       (rr_ptr_q),
        .gnt       (arb_gnt_s),
        .gnt_idx   (arb_idx_s),
        .gnt_valid (arb_valid_s)
    );

    // Lowest-index free VC, judged on registered state so a release lands a cycle later.
    always_comb begin
        any_free_s = 1'b0;
        free_vc_s  = '0;
        for (int v = VIRTUAL_CHANNELS - 1; v >= 0; v--) begin
            if (vc_is_free(vc_busy_q[v], credits_q[v])) begin
                any_free_s = 1'b1;
                free_vc_s  = VC_BITS'(v);
            end else begin
                any_free_s = any_free_s;
            end
        end
    end

    // Grant outputs; reset gates them combinationally so nothing leaks during reset.
    always_comb begin
        grant_s = reset && any_free_s && arb_valid_s;
        gnt_vc  = free_vc_s;
        if (grant_s) begin
            gnt = arb_gnt_s;
        end else begin
            gnt = '0;
        end
    end

    // Next-state for ownership, credits, pointer and the sticky error flag.
    always_comb begin
        vc_busy_d = vc_busy_q;
        credits_d = credits_q;
        err_d     = err_q;
        rr_ptr_d  = rr_ptr_q;

        if (grant_s) begin
            if (arb_idx_s == REQ_BITS'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = arb_idx_s + REQ_BITS'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end

        for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
            if (release_valid && (release_vc == VC_BITS'(v))) begin
                if (vc_busy_q[v]) begin
                    vc_busy_d[v] = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                vc_busy_d[v] = vc_busy_d[v];
            end

            // A granted VC was idle, so a same-cycle release of it is already an error.
            if (grant_s && (free_vc_s == VC_BITS'(v))) begin
                vc_busy_d[v] = 1'b1;
            end else begin
                vc_busy_d[v] = vc_busy_d[v];
            end

            case ({flit_sent && (flit_sent_vc == VC_BITS'(v)),
                   credit_return && (credit_return_vc == VC_BITS'(v))})
                2'b10: begin
                    if (credits_q[v] == credit_t'(0)) begin
                        err_d = 1'b1;
                    end else begin
                        credits_d[v] = credits_q[v] - credit_t'(1);
                    end
                end
                2'b01: begin
                    if (credits_q[v] == CREDIT_FULL) begin
                        err_d = 1'b1;
                    end else begin
                        credits_d[v] = credits_q[v] + credit_t'(1);
                    end
                end
                default: begin
                    credits_d[v] = credits_q[v];
                end
            endcase
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vc_busy_q <= '0;
            rr_ptr_q  <= '0;
            err_q     <= 1'b0;
            for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
                credits_q[v] <= CREDIT_FULL;
            end
        end else begin
            vc_busy_q <= vc_busy_d;
            rr_ptr_q  <= rr_ptr_d;
            err_q     <= err_d;
            credits_q <= credits_d;
        end
    end

    // Pack the counters onto the output bus, VC v in slice v.
    always_comb begin
        credits = '0;
        for (int v = 0; v < VIRTUAL_CHANNELS; v++) begin
            credits[v*CNT_BITS +: CNT_BITS] = credits_q[v];
        end
        vc_busy = vc_busy_q;
        err     = err_q;
    end

endmodule

// File: tb/tb_vc_allocator.sv
// Directed self-checking bench for vc_allocator with hand-computed expectations.
module tb_vc_allocator;
    import vc_allocator_pkg::*;

    localparam int NREQ = 10;

    logic                                 clk;
    logic                                 reset;
    logic [NREQ-1:0]                      req;
    logic [NREQ-1:0]                      gnt;
    logic [VC_BITS-1:0]                   gnt_vc;
    logic                                 release_valid;
    logic [VC_BITS-1:0]                   release_vc;
    logic                                 flit_sent;
    logic [VC_BITS-1:0]                   flit_sent_vc;
    logic                                 credit_return;
    logic [VC_BITS-1:0]                   credit_return_vc;
    logic [VIRTUAL_CHANNELS-1:0]          vc_busy;
    logic [VIRTUAL_CHANNELS*CNT_BITS-1:0] credits;
    logic                                 err;

    int vectors;
    int miscompares;

    vc_allocator dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .gnt              (gnt),
        .gnt_vc           (gnt_vc),
        .release_valid    (release_valid),
        .release_vc       (release_vc),
        .flit_sent        (flit_sent),
        .flit_sent_vc     (flit_sent_vc),
        .credit_return    (credit_return),
        .credit_return_vc (credit_return_vc),
        .vc_busy          (vc_busy),
        .credits          (credits),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        req              = '0;
        release_valid    = 1'b0;
        release_vc       = '0;
        flit_sent        = 1'b0;
        flit_sent_vc     = '0;
        credit_return    = 1'b0;
        credit_return_vc = '0;
        tick();
        tick();
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req   = 10'h3FF;
        #1;
        vectors++;
        if (gnt !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_gnt_forced: got %h expected %h", gnt, 10'h000);
        end
        tick();
        reset = 1'b1;
        req   = 10'h000;
        #1;
        vectors++;
        if (vc_busy !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_vc_busy: got %b expected %b", vc_busy, 2'b00);
        end
        vectors++;
        if (credits !== 8'h55) begin
            miscompares++;
            $display("FAIL reset_credits: got %h expected %h", credits, 8'h55);
        end
        vectors++;
        if (err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_err: got %b expected %b", err, 1'b0);
        end
        vectors++;
        if (gnt !== 10'h000) begin
            miscompares++;
            $display("FAIL reset_gnt_idle: got %h expected %h", gnt, 10'h000);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 10'h008;
        #1;
        vectors++;
        if (gnt !== 10'h008) begin
            miscompares++;
            $display("FAIL single_gnt: got %h expected %h", gnt, 10'h008);
        end
        vectors++;
        if (gnt_vc !== 1'b0) begin
            miscompares++;
            $display("FAIL single_gnt_vc: got %h expected %h", gnt_vc, 1'b0);
        end
        tick();
        req = 10'h000;
        #1;
        vectors++;
        if (vc_busy !== 2'b01) begin
            miscompares++;
            $display("FAIL single_vc_busy: got %b expected %b", vc_busy, 2'b01);
        end
        release_valid = 1'b1;
        release_vc    = 1'b0;
        tick();
        release_valid = 1'b0;
        #1;
        vectors++;
        if (vc_busy !== 2'b00) begin
            miscompares++;
            $display("FAIL single_release: got %b expected %b", vc_busy, 2'b00);
        end
        // pointer should now sit at 4, so 4 beats 3
        req = 10'h018;
        #1;
        vectors++;
        if (gnt !== 10'h010) begin
            miscompares++;
            $display("FAIL single_rr_ptr: got %h expected %h", gnt, 10'h010);
        end
        tick();
        req = 10'h000;
    endtask

    task automatic test_round_robin();
        do_reset();
        req = 10'h282;
        #1;
        vectors++;
        if (gnt !== 10'h002 || gnt_vc !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_first: got gnt=%h vc=%h expected gnt=%h vc=%h", gnt, gnt_vc, 10'h002, 1'b0);
        end
        tick();
        req = 10'h280;
        #1;
        vectors++;
        if (gnt !== 10'h080 || gnt_vc !== 1'b1) begin
            miscompares++;
            $display("FAIL rr_second: got gnt=%h vc=%h expected gnt=%h vc=%h", gnt, gnt_vc, 10'h080, 1'b1);
        end
        tick();
        req = 10'h200;
        #1;
        vectors++;
        if (gnt !== 10'h000) begin
            miscompares++;
            $display("FAIL rr_exhausted: got %h expected %h", gnt, 10'h000);
        end
        tick();
        vectors++;
        if (gnt !== 10'h000 || vc_busy !== 2'b11) begin
            miscompares++;
            $display("FAIL rr_exhausted_hold: got gnt=%h busy=%b expected gnt=%h busy=%b", gnt, vc_busy, 10'h000, 2'b11);
        end
        release_valid = 1'b1;
        release_vc    = 1'b0;
        #1;
        vectors++;
        if (gnt !== 10'h000) begin
            miscompares++;
            $display("FAIL rr_release_same_cycle: got %h expected %h", gnt, 10'h000);
        end
        tick();
        release_valid = 1'b0;
        #1;
        vectors++;
        if (gnt !== 10'h200 || gnt_vc !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_after_release: got gnt=%h vc=%h expected gnt=%h vc=%h", gnt, gnt_vc, 10'h200, 1'b0);
        end
        tick();
        req = 10'h000;
        #1;
        vectors++;
        if (vc_busy !== 2'b11) begin
            miscompares++;
            $display("FAIL rr_final_busy: got %b expected %b", vc_busy, 2'b11);
        end
    endtask

    task automatic test_drain_gating();
        do_reset();
        req = 10'h001;
        tick();
        req = 10'h002;
        tick();
        req          = 10'h000;
        flit_sent    = 1'b1;
        flit_sent_vc = 1'b1;
        tick();
        tick();
        flit_sent = 1'b0;
        #1;
        vectors++;
        if (credits !== 8'h35 || vc_busy !== 2'b11) begin
            miscompares++;
            $display("FAIL drain_sent: got credits=%h busy=%b expected credits=%h busy=%b", credits, vc_busy, 8'h35, 2'b11);
        end
        release_valid = 1'b1;
        release_vc    = 1'b1;
        tick();
        release_valid = 1'b0;
        req           = 10'h004;
        #1;
        vectors++;
        if (vc_busy !== 2'b01 || gnt !== 10'h000) begin
            miscompares++;
            $display("FAIL drain_gated: got busy=%b gnt=%h expected busy=%b gnt=%h", vc_busy, gnt, 2'b01, 10'h000);
        end
        credit_return    = 1'b1;
        credit_return_vc = 1'b1;
        tick();
        vectors++;
        if (credits !== 8'h45 || gnt !== 10'h000) begin
            miscompares++;
            $display("FAIL drain_partial: got credits=%h gnt=%h expected credits=%h gnt=%h", credits, gnt, 8'h45, 10'h000);
        end
        tick();
        credit_return = 1'b0;
        #1;
        vectors++;
        if (credits !== 8'h55 || gnt !== 10'h004 || gnt_vc !== 1'b1) begin
            miscompares++;
            $display("FAIL drain_regrant: got credits=%h gnt=%h vc=%h expected credits=%h gnt=%h vc=%h", credits, gnt, gnt_vc, 8'h55, 10'h004, 1'b1);
        end
        tick();
        req = 10'h000;
        #1;
        vectors++;
        if (vc_busy !== 2'b11) begin
            miscompares++;
            $display("FAIL drain_busy: got %b expected %b", vc_busy, 2'b11);
        end
    endtask

    task automatic test_credits_simul();
        do_reset();
        flit_sent        = 1'b1;
        flit_sent_vc     = 1'b0;
        credit_return    = 1'b1;
        credit_return_vc = 1'b0;
        tick();
        vectors++;
        if (credits !== 8'h55 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_same_full: got credits=%h err=%b expected credits=%h err=%b", credits, err, 8'h55, 1'b0);
        end
        credit_return = 1'b0;
        tick();
        vectors++;
        if (credits !== 8'h54) begin
            miscompares++;
            $display("FAIL simul_single_dec: got %h expected %h", credits, 8'h54);
        end
        flit_sent_vc     = 1'b1;
        credit_return    = 1'b1;
        credit_return_vc = 1'b0;
        tick();
        vectors++;
        if (credits !== 8'h45 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_diff_vc: got credits=%h err=%b expected credits=%h err=%b", credits, err, 8'h45, 1'b0);
        end
        credit_return_vc = 1'b1;
        tick();
        vectors++;
        if (credits !== 8'h45) begin
            miscompares++;
            $display("FAIL simul_same_mid: got %h expected %h", credits, 8'h45);
        end
        flit_sent = 1'b0;
        tick();
        credit_return = 1'b0;
        vectors++;
        if (credits !== 8'h55 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL simul_inc: got credits=%h err=%b expected credits=%h err=%b", credits, err, 8'h55, 1'b0);
        end
    endtask

    task automatic test_errors();
        do_reset();
        flit_sent    = 1'b1;
        flit_sent_vc = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
        end
        vectors++;
        if (credits !== 8'h50 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_empty_ok: got credits=%h err=%b expected credits=%h err=%b", credits, err, 8'h50, 1'b0);
        end
        tick();
        flit_sent = 1'b0;
        vectors++;
        if (credits !== 8'h50 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_underflow: got credits=%h err=%b expected credits=%h err=%b", credits, err, 8'h50, 1'b1);
        end
        tick();
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: got %b expected %b", err, 1'b1);
        end

        do_reset();
        credit_return    = 1'b1;
        credit_return_vc = 1'b1;
        tick();
        credit_return = 1'b0;
        vectors++;
        if (credits !== 8'h55 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_overflow: got credits=%h err=%b expected credits=%h err=%b", credits, err, 8'h55, 1'b1);
        end

        do_reset();
        release_valid = 1'b1;
        release_vc    = 1'b1;
        tick();
        release_valid = 1'b0;
        vectors++;
        if (vc_busy !== 2'b00 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_idle_release: got busy=%b err=%b expected busy=%b err=%b", vc_busy, err, 2'b00, 1'b1);
        end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 10'h001;
        tick();
        req          = 10'h000;
        flit_sent    = 1'b1;
        flit_sent_vc = 1'b0;
        tick();
        flit_sent     = 1'b0;
        release_valid = 1'b1;
        release_vc    = 1'b1;
        tick();
        release_valid = 1'b0;
        vectors++;
        if (credits !== 8'h54 || vc_busy !== 2'b01 || err !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_setup: got credits=%h busy=%b err=%b expected credits=%h busy=%b err=%b", credits, vc_busy, err, 8'h54, 2'b01, 1'b1);
        end
        req = 10'h020;
        #1;
        vectors++;
        if (gnt !== 10'h020 || gnt_vc !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_grant: got gnt=%h vc=%h expected gnt=%h vc=%h", gnt, gnt_vc, 10'h020, 1'b1);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (gnt !== 10'h000) begin
            miscompares++;
            $display("FAIL mid_reset_gnt: got %h expected %h", gnt, 10'h000);
        end
        vectors++;
        if (vc_busy !== 2'b00 || credits !== 8'h55 || err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_state: got busy=%b credits=%h err=%b expected busy=%b credits=%h err=%b", vc_busy, credits, err, 2'b00, 8'h55, 1'b0);
        end
        tick();
        reset = 1'b1;
        req   = 10'h021;
        #1;
        // pointer was 1 before reset; reloaded to 0 so requester 0 wins
        vectors++;
        if (gnt !== 10'h001 || gnt_vc !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_ptr: got gnt=%h vc=%h expected gnt=%h vc=%h", gnt, gnt_vc, 10'h001, 1'b0);
        end
        tick();
        req = 10'h000;
    endtask

    initial begin
        vectors          = 0;
        miscompares      = 0;
        reset            = 1'b0;
        req              = '0;
        release_valid    = 1'b0;
        release_vc       = '0;
        flit_sent        = 1'b0;
        flit_sent_vc     = '0;
        credit_return    = 1'b0;
        credit_return_vc = '0;
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_drain_gating();
        test_credits_simul();
        test_errors();
        test_reset_mid_grant();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
